// File: rtl/icache_fetcher_if.sv
// Fetcher-side bundle: miss request/response toward the MMU, queue head toward the issuer, and redirect.
// The master modport is the fetcher's view; the slave modport is the MMU/issuer/redirect side.
interface icache_fetcher_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  valid_to_mem_mgmt_unit;
    logic [ADDR_WIDTH-1:0] addr_to_mem_mgmt_unit;
    logic                  ready_from_mem_mgmt_unit;
    logic [31:0]           inst_from_mem_mgmt_unit;
    logic                  valid_to_issuer;
    logic [31:0]           inst_to_issuer;
    logic [ADDR_WIDTH-1:0] pc_to_issuer;
    logic                  ready_from_issuer;
    logic                  jump_valid;
    logic [ADDR_WIDTH-1:0] jump_addr;

    modport master (
        output valid_to_mem_mgmt_unit,
        output addr_to_mem_mgmt_unit,
        input  ready_from_mem_mgmt_unit,
        input  inst_from_mem_mgmt_unit,
        output valid_to_issuer,
        output inst_to_issuer,
        output pc_to_issuer,
        input  ready_from_issuer,
        input  jump_valid,
        input  jump_addr
    );

    modport slave (
        input  valid_to_mem_mgmt_unit,
        input  addr_to_mem_mgmt_unit,
        output ready_from_mem_mgmt_unit,
        output inst_from_mem_mgmt_unit,
        input  valid_to_issuer,
        input  inst_to_issuer,
        input  pc_to_issuer,
        output ready_from_issuer,
        output jump_valid,
        output jump_addr
    );
endinterface

// File: rtl/icache_fetcher.sv
// Sequential fetcher: direct-mapped I$ plus prefetch queue; hit reaches the issuer 1 cycle after lookup.
// One miss outstanding at a time; lookups stall while the queue is full, and rdy low freezes everything.
module icache_fetcher #(
    parameter int                    CACHE_INDEX_WIDTH = 4,
    parameter int                    QUEUE_DEPTH_LOG   = 2,
    parameter int                    ADDR_WIDTH        = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC          = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    icache_fetcher_if.master   bus
);
    localparam int LINES = 1 << CACHE_INDEX_WIDTH;
    localparam int DEPTH = 1 << QUEUE_DEPTH_LOG;
    localparam int TAG_W = ADDR_WIDTH - CACHE_INDEX_WIDTH - 2;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT      = 2'd1;
    localparam logic [1:0] ST_WAIT_DROP = 2'd2;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] req_pc;

    logic [31:0]      line_data [LINES];
    logic [TAG_W-1:0] line_tag  [LINES];
    logic [LINES-1:0] line_vld;

    logic [31:0]              q_inst [DEPTH];
    logic [ADDR_WIDTH-1:0]    q_pc   [DEPTH];
    logic [QUEUE_DEPTH_LOG-1:0] head;
    logic [QUEUE_DEPTH_LOG-1:0] tail;
    logic [QUEUE_DEPTH_LOG:0]   count;

    logic [CACHE_INDEX_WIDTH-1:0] fetch_idx;
    logic [CACHE_INDEX_WIDTH-1:0] req_idx;
    logic [TAG_W-1:0]             fetch_tag;
    logic [TAG_W-1:0]             req_tag;
    logic                         q_full;
    logic                         q_empty;
    logic                         hit;
    logic                         mem_rsp;
    logic                         lookup;
    logic                         push_hit;
    logic                         issue_miss;
    logic                         push_fill;
    logic                         push;
    logic                         pop;
    logic [ADDR_WIDTH-1:0]        push_pc;
    logic [31:0]                  push_inst;

    assign fetch_idx = fetch_pc[CACHE_INDEX_WIDTH+1:2];
    assign fetch_tag = fetch_pc[ADDR_WIDTH-1:CACHE_INDEX_WIDTH+2];
    assign req_idx   = req_pc[CACHE_INDEX_WIDTH+1:2];
    assign req_tag   = req_pc[ADDR_WIDTH-1:CACHE_INDEX_WIDTH+2];

    // Full is judged on the registered count only, so a same-cycle pop never admits a push.
    assign q_full  = (count == (QUEUE_DEPTH_LOG+1)'(DEPTH));
    assign q_empty = (count == '0);

    assign hit     = line_vld[fetch_idx] && (line_tag[fetch_idx] == fetch_tag);
    assign mem_rsp = (state != ST_IDLE) && bus.ready_from_mem_mgmt_unit;

    assign lookup     = (state == ST_IDLE) && !q_full && !bus.jump_valid;
    assign push_hit   = lookup && hit;
    assign issue_miss = lookup && !hit;
    assign push_fill  = (state == ST_WAIT) && mem_rsp && !bus.jump_valid;
    assign push       = push_hit || push_fill;
    assign pop        = !q_empty && bus.ready_from_issuer && !bus.jump_valid;

    assign push_pc   = push_fill ? req_pc : fetch_pc;
    assign push_inst = push_fill ? bus.inst_from_mem_mgmt_unit : line_data[fetch_idx];

    assign bus.valid_to_mem_mgmt_unit = (state != ST_IDLE);
    assign bus.addr_to_mem_mgmt_unit  = req_pc;
    assign bus.valid_to_issuer        = !q_empty;
    assign bus.inst_to_issuer         = q_empty ? 32'h0 : q_inst[head];
    assign bus.pc_to_issuer           = q_empty ? '0 : q_pc[head];

    // Storage arrays carry no reset; only their valid/occupancy state is cleared.
    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            if (mem_rsp) begin
                line_data[req_idx] <= bus.inst_from_mem_mgmt_unit;
                line_tag[req_idx]  <= req_tag;
            end
            if (push) begin
                q_inst[tail] <= push_inst;
                q_pc[tail]   <= push_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            line_vld <= '0;
        end else if (rdy) begin
            if (mem_rsp) begin
                line_vld[req_idx] <= 1'b1;
            end
            if (bus.jump_valid) begin
                // A miss in flight is still waited out, but its result is only cached.
                fetch_pc <= bus.jump_addr;
                if (state != ST_IDLE) begin
                    state <= mem_rsp ? ST_IDLE : ST_WAIT_DROP;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (push_hit) begin
                            fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                        end else if (issue_miss) begin
                            req_pc <= fetch_pc;
                            state  <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (mem_rsp) begin
                            fetch_pc <= req_pc + ADDR_WIDTH'(4);
                            state    <= ST_IDLE;
                        end
                    end
                    ST_WAIT_DROP: begin
                        if (mem_rsp) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (bus.jump_valid) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    tail <= tail + QUEUE_DEPTH_LOG'(1);
                end
                if (pop) begin
                    head <= head + QUEUE_DEPTH_LOG'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + (QUEUE_DEPTH_LOG+1)'(1);
                    2'b01:   count <= count - (QUEUE_DEPTH_LOG+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: doc/icache_fetcher.md
# icache_fetcher

Parametrised instruction fetcher with a direct-mapped instruction cache and a prefetch queue. It sits between the memory management unit and the issuer. It fetches sequentially from its own PC and keeps at most one miss outstanding to memory. Fetched instructions are buffered, with their PCs, in a FIFO drained by a valid/ready handshake. An external redirect flushes the queue, discards any in-flight miss result, and restarts fetch at a new address.

## Interface
- CACHE_INDEX_WIDTH, 4: log2 of cache lines. One 32-bit instruction per line.
- QUEUE_DEPTH_LOG, 2: log2 of prefetch queue entries.
- ADDR_WIDTH, 32: address/PC width.
- RESET_PC, 0: fetch PC after reset.
- clk  in  1  clock; everything is clocked on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable. When low, all state and outputs hold and all inputs are ignored.
- valid_to_mem_mgmt_unit  out  1  miss request valid; held high until accepted.
- addr_to_mem_mgmt_unit  out  ADDR_WIDTH  miss address; stable while the request is valid.
- ready_from_mem_mgmt_unit  in  1  one-cycle pulse; inst_from_mem_mgmt_unit is valid in that cycle.
- inst_from_mem_mgmt_unit  in  32  returned instruction.
- valid_to_issuer  out  1  queue non-empty.
- inst_to_issuer  out  32  head instruction.
- pc_to_issuer  out  ADDR_WIDTH  head PC.
- ready_from_issuer  in  1  pops the head when valid_to_issuer is also high.
- jump_valid  in  1  redirect request.
- jump_addr  in  ADDR_WIDTH  redirect target, word aligned.

## Operation
- Address split: index = pc[CACHE_INDEX_WIDTH+1:2]; tag = pc[ADDR_WIDTH-1:CACHE_INDEX_WIDTH+2]; pc[1:0] is ignored.
- Reset: all cache valid bits cleared. fetch_pc = RESET_PC. Queue empty. State IDLE.
- Reset values of outputs: valid_to_mem_mgmt_unit = 0, addr_to_mem_mgmt_unit = 0, valid_to_issuer = 0, inst_to_issuer = 0, pc_to_issuer = 0.
- States: IDLE, WAIT, WAIT_DROP.
- IDLE, queue not full, no redirect:
  - On a hit, push {fetch_pc, line} and set fetch_pc += 4.
  - On a miss, latch req_pc = fetch_pc, assert the request with addr = fetch_pc, and go to WAIT.
- IDLE, queue full: no lookup and no request.
- WAIT, on ready_from_mem_mgmt_unit:
  - Write the line, tag and valid bit at req_pc's index.
  - Push {req_pc, inst}. A free slot is guaranteed, because a miss is only issued when not full and pops only free space.
  - Set fetch_pc = req_pc + 4, deassert the request, go to IDLE.
- WAIT_DROP, on ready_from_mem_mgmt_unit: write the cache as in WAIT, but push nothing, then go to IDLE. fetch_pc already holds the redirect target.
- Redirect (jump_valid) has highest priority:
  - Queue emptied, and any push or pop in that cycle is cancelled.
  - fetch_pc = jump_addr.
  - From WAIT, go to WAIT_DROP; the request stays asserted until accepted.
  - From IDLE, stay IDLE with no lookup that cycle.
  - From WAIT_DROP, stay in WAIT_DROP.
- Redirect in the same cycle as ready_from_mem_mgmt_unit: the cache is written, nothing is pushed, state goes to IDLE, fetch_pc = jump_addr.
- Queue arithmetic:
  - Head and tail pointers are QUEUE_DEPTH_LOG bits and wrap modulo depth.
  - count is QUEUE_DEPTH_LOG+1 bits.
  - Push and pop in the same cycle leave count unchanged.
  - Full is count == depth, judged on the registered count. A pop in the same cycle does not unblock a push (no bypass).
- fetch_pc wraps modulo 2^ADDR_WIDTH.

## Timing
- Hit: lookup in cycle N; the entry is visible on the issuer outputs in N+1, if the queue was empty.
- Sustained hits: 1 instruction/cycle while the issuer pops every cycle and the queue is not full.
- Miss: lookup in N; valid_to_mem_mgmt_unit high from N+1.
- Response with ready in cycle M:
  - The entry is visible to the issuer in M+1.
  - The line is visible to lookups from M+1.
  - The next lookup (req_pc+4) happens in M+1.
- Pop: with valid and ready high in cycle N, the next head is presented in N+1.
- Redirect in cycle N: valid_to_issuer = 0 in N+1; the first lookup at jump_addr happens in N+1.
- rdy low for K cycles stretches every latency above by exactly K cycles, with no lost or duplicated events.

## Test plan
- Cold start, RESET_PC = 0, memory answers 3 cycles after each request: requests go out to 0x0, 0x4, 0x8 in order. The issuer receives (0x0, I0), (0x4, I1), (0x8, I2), with no duplicates.
- Warm loop:
  - Stimulus: after the first pass, jump to 0x0 again.
  - Required: no memory request is issued; 3 entries arrive on consecutive cycles.
- Queue full:
  - Stimulus: hold ready_from_issuer = 0 with depth 4 and all lines hit.
  - Required: exactly 4 entries are queued, then lookups stop.
  - Required: after releasing ready, PCs 0x0, 0x4, 0x8, 0xC come out in order, then fetch resumes at 0x10.
- Redirect during a miss:
  - Stimulus: jump to 0x40 while a request for 0x8 is outstanding.
  - Required: the 0x8 response is cached but never queued.
  - Required: the first entry after the jump has pc 0x40.
  - Required: a later jump to 0x8 hits.
- Conflict eviction, CACHE_INDEX_WIDTH = 4: fetching 0x0 and then 0x40 (same index, different tag) makes a re-fetch of 0x0 miss.
- Stall and reset:
  - Stimulus: drop rdy for 5 cycles mid-miss.
  - Required: all outputs hold; the response arrives after rdy returns and is queued once.
  - Stimulus: assert rst mid-miss.
  - Required: next cycle, all outputs are 0 and the queue is empty; the following lookup at RESET_PC misses.
